// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int DEF_AW      = 32;
    localparam int DEF_DW      = 32;
    localparam int DEF_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    typedef logic port_id_t;

    localparam port_id_t PORT_I = 1'b0;
    localparam port_id_t PORT_D = 1'b1;

endpackage

// File: rtl/mem_arb_timer.sv
// Busy-cycle watchdog: counts stalled cycles and flags the cycle in which
// the count would reach TIMEOUT.
module mem_arb_timer
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int            CW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q, count_d;

    // Next count: clear has priority over counting.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CW'(1);
        end
    end

    // This stalled cycle is the one that brings the count to TIMEOUT.
    assign expired = enable && !clear && (count_q == LAST);

    // Counter register.
    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignments so all registers update together.
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-refill port and a data port onto one memory
// interface, one transaction at a time, with a busy-cycle timeout.
// Optional feature: define MEM_ARB_RR_EN for round-robin on contention;
// otherwise the data port always wins.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_ireq,
    input  logic [AW-1:0] i_iaddr,
    output logic [DW-1:0] o_idata,
    output logic          o_ivd,
    input  logic          i_dren,
    input  logic          i_dwen,
    input  logic [AW-1:0] i_daddr,
    input  logic [DW-1:0] i_dwdata,
    output logic [DW-1:0] o_ddata,
    output logic          o_dvd,
    output logic [AW-1:0] o_mem_addr,
    output logic          o_mem_ren,
    output logic          o_mem_wen,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata,
    input  logic          i_mem_vd,
    output logic          o_busy,
    output logic          o_timeout
);

    arb_state_t    state_q, state_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          mem_ren_q, mem_ren_d;
    logic          mem_wen_q, mem_wen_d;
    logic [DW-1:0] idata_q, idata_d;
    logic [DW-1:0] ddata_q, ddata_d;
    logic          ivd_q, ivd_d;
    logic          dvd_q, dvd_d;
    logic          timeout_q, timeout_d;

    logic          d_req, any_req, in_busy;
    logic          timer_clear, timer_enable, timer_expired;
    port_id_t      winner;

`ifdef MEM_ARB_RR_EN
    port_id_t      last_grant_q, last_grant_d;
`endif

    assign d_req   = i_dren | i_dwen;
    assign any_req = d_req | i_ireq;
    assign in_busy = (state_q == IBUSY) || (state_q == DBUSY);

`ifdef MEM_ARB_RR_EN
    assign winner = (d_req && (!i_ireq || last_grant_q == PORT_I)) ? PORT_D : PORT_I;
`else
    assign winner = d_req ? PORT_D : PORT_I;
`endif

    assign timer_clear  = (state_q == IDLE) && any_req;
    assign timer_enable = in_busy && !i_mem_vd;

    mem_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    // Next-state and registered-output logic for the arbiter FSM.
    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_ren_d   = mem_ren_q;
        mem_wen_d   = mem_wen_q;
        idata_d     = idata_q;
        ddata_d     = ddata_q;
        ivd_d       = 1'b0;
        dvd_d       = 1'b0;
        timeout_d   = 1'b0;
`ifdef MEM_ARB_RR_EN
        last_grant_d = last_grant_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
`ifdef MEM_ARB_RR_EN
                    last_grant_d = winner;
`endif
                    if (winner == PORT_D) begin
                        state_d     = DBUSY;
                        mem_addr_d  = i_daddr;
                        mem_wen_d   = i_dwen;
                        mem_ren_d   = !i_dwen;
                        mem_wdata_d = i_dwen ? i_dwdata : '0;
                    end else begin
                        state_d     = IBUSY;
                        mem_addr_d  = i_iaddr;
                        mem_ren_d   = 1'b1;
                        mem_wen_d   = 1'b0;
                        mem_wdata_d = '0;
                    end
                end
            end
            IBUSY, DBUSY: begin
                // Completion beats a timeout landing in the same cycle.
                if (i_mem_vd) begin
                    state_d   = DONE;
                    mem_ren_d = 1'b0;
                    mem_wen_d = 1'b0;
                    if (state_q == IBUSY) begin
                        ivd_d   = 1'b1;
                        idata_d = i_mem_rdata;
                    end else begin
                        dvd_d = 1'b1;
                        if (!mem_wen_q) begin
                            ddata_d = i_mem_rdata;
                        end
                    end
                end else if (timer_expired) begin
                    state_d   = IDLE;
                    mem_ren_d = 1'b0;
                    mem_wen_d = 1'b0;
                    timeout_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the read-data holding registers are reset too, so every output reads 0 in reset.
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_ren_q   <= 1'b0;
            mem_wen_q   <= 1'b0;
            idata_q     <= '0;
            ddata_q     <= '0;
            ivd_q       <= 1'b0;
            dvd_q       <= 1'b0;
            timeout_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= PORT_I;
`endif
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_ren_q   <= mem_ren_d;
            mem_wen_q   <= mem_wen_d;
            idata_q     <= idata_d;
            ddata_q     <= ddata_d;
            ivd_q       <= ivd_d;
            dvd_q       <= dvd_d;
            timeout_q   <= timeout_d;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_mem_ren   = mem_ren_q;
    assign o_mem_wen   = mem_wen_q;
    assign o_idata     = idata_q;
    assign o_ddata     = ddata_q;
    assign o_ivd       = ivd_q;
    assign o_dvd       = dvd_q;
    assign o_timeout   = timeout_q;
    assign o_busy      = in_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter. A second instance built
// with TIMEOUT=4 shares the stimulus and is used for the watchdog cases.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_ireq;
    logic [31:0] i_iaddr;
    logic        i_dren;
    logic        i_dwen;
    logic [31:0] i_daddr;
    logic [31:0] i_dwdata;
    logic [31:0] i_mem_rdata;
    logic        i_mem_vd;

    logic [31:0] o_idata, o_ddata, o_mem_addr, o_mem_wdata;
    logic        o_ivd, o_dvd, o_mem_ren, o_mem_wen, o_busy, o_timeout;
    logic [31:0] t_idata, t_ddata, t_mem_addr, t_mem_wdata;
    logic        t_ivd, t_dvd, t_mem_ren, t_mem_wen, t_busy, t_timeout;

    logic [133:0] main_outs, t_outs;
    assign main_outs = {o_idata, o_ivd, o_ddata, o_dvd, o_mem_addr, o_mem_ren,
                        o_mem_wen, o_mem_wdata, o_busy, o_timeout};
    assign t_outs    = {t_idata, t_ivd, t_ddata, t_dvd, t_mem_addr, t_mem_ren,
                        t_mem_wen, t_mem_wdata, t_busy, t_timeout};

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_idata;
    logic [31:0] exp_ddata;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .i_ireq(i_ireq), .i_iaddr(i_iaddr), .o_idata(o_idata), .o_ivd(o_ivd),
        .i_dren(i_dren), .i_dwen(i_dwen), .i_daddr(i_daddr), .i_dwdata(i_dwdata),
        .o_ddata(o_ddata), .o_dvd(o_dvd),
        .o_mem_addr(o_mem_addr), .o_mem_ren(o_mem_ren), .o_mem_wen(o_mem_wen),
        .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata), .i_mem_vd(i_mem_vd),
        .o_busy(o_busy), .o_timeout(o_timeout)
    );

    mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut_to (
        .clk(clk), .rst(rst),
        .i_ireq(i_ireq), .i_iaddr(i_iaddr), .o_idata(t_idata), .o_ivd(t_ivd),
        .i_dren(i_dren), .i_dwen(i_dwen), .i_daddr(i_daddr), .i_dwdata(i_dwdata),
        .o_ddata(t_ddata), .o_dvd(t_dvd),
        .o_mem_addr(t_mem_addr), .o_mem_ren(t_mem_ren), .o_mem_wen(t_mem_wen),
        .o_mem_wdata(t_mem_wdata), .i_mem_rdata(i_mem_rdata), .i_mem_vd(i_mem_vd),
        .o_busy(t_busy), .o_timeout(t_timeout)
    );

    // Advance to just after the next rising edge; drive and sample there.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; i_ireq = 1'b1; i_iaddr = 32'h10; i_dren = 1'b1; i_dwen = 1'b0;
        i_daddr = 32'h20; i_dwdata = 32'h0; i_mem_rdata = 32'hFFFF_FFFF; i_mem_vd = 1'b1;
        tick; tick; tick;
        checks++;
        if (main_outs !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h want 0", main_outs);
        end
        checks++;
        if (t_outs !== '0) begin
            errors++; $display("FAIL reset_outputs_to: got %h want 0", t_outs);
        end
        i_ireq = 1'b0; i_dren = 1'b0; i_mem_vd = 1'b0;
        tick;
        rst = 1'b0;
        tick;
        checks++;
        if (main_outs !== '0) begin
            errors++; $display("FAIL reset_release_idle: got %h want 0", main_outs);
        end
    endtask

    task automatic test_ifetch;
        i_ireq = 1'b1; i_iaddr = 32'h100;
        tick;
        i_ireq = 1'b0;
        checks++;
        if ({o_busy, o_mem_ren, o_mem_wen, o_mem_addr} !== {3'b110, 32'h100}) begin
            errors++; $display("FAIL ifetch_issue: got %b/%h want 110/00000100",
                               {o_busy, o_mem_ren, o_mem_wen}, o_mem_addr);
        end
        i_mem_vd = 1'b1; i_mem_rdata = 32'hDEAD_BEEF;
        tick;
        i_mem_vd = 1'b0;
        exp_idata = 32'hDEAD_BEEF;
        checks++;
        if ({o_ivd, o_dvd, o_busy, o_mem_ren, o_idata} !== {4'b1000, exp_idata}) begin
            errors++; $display("FAIL ifetch_complete: got %b/%h want 1000/%h",
                               {o_ivd, o_dvd, o_busy, o_mem_ren}, o_idata, exp_idata);
        end
        tick;
        checks++;
        if ({o_ivd, o_idata} !== {1'b0, exp_idata}) begin
            errors++; $display("FAIL ifetch_pulse_end: got %b/%h want 0/%h", o_ivd, o_idata, exp_idata);
        end
    endtask

    task automatic test_contention;
        logic [31:0] exp_addr;
        // Round 1: both request, data wins in either build.
        i_ireq = 1'b1; i_iaddr = 32'h40; i_dren = 1'b1; i_daddr = 32'h80;
        tick;
        i_ireq = 1'b0; i_dren = 1'b0;
        checks++;
        if ({o_mem_ren, o_mem_addr} !== {1'b1, 32'h80}) begin
            errors++; $display("FAIL contend1_grant: got %b/%h want 1/00000080", o_mem_ren, o_mem_addr);
        end
        i_mem_vd = 1'b1; i_mem_rdata = 32'h0000_A5A5;
        tick;
        i_mem_vd = 1'b0;
        checks++;
        if ({o_dvd, o_ivd, o_ddata} !== {2'b10, 32'h0000_A5A5}) begin
            errors++; $display("FAIL contend1_done: got %b/%h want 10/0000a5a5", {o_dvd, o_ivd}, o_ddata);
        end
        tick;
        // Round 2: both request again; the loser stays asserted.
        i_ireq = 1'b1; i_dren = 1'b1;
        tick;
`ifdef MEM_ARB_RR_EN
        exp_addr = 32'h40; i_ireq = 1'b0;
`else
        exp_addr = 32'h80; i_dren = 1'b0;
`endif
        checks++;
        if ({o_mem_ren, o_mem_addr} !== {1'b1, exp_addr}) begin
            errors++; $display("FAIL contend2_grant: got %b/%h want 1/%h", o_mem_ren, o_mem_addr, exp_addr);
        end
        i_mem_vd = 1'b1; i_mem_rdata = 32'h0000_B0B0;
        tick;
        i_mem_vd = 1'b0;
        checks++;
        if (o_busy !== 1'b0 || o_mem_ren !== 1'b0) begin
            errors++; $display("FAIL contend2_done: got busy=%b ren=%b want 0/0", o_busy, o_mem_ren);
        end
        tick;
        tick;
`ifdef MEM_ARB_RR_EN
        exp_addr = 32'h80; i_dren = 1'b0;
`else
        exp_addr = 32'h40; i_ireq = 1'b0;
`endif
        checks++;
        if ({o_busy, o_mem_ren, o_mem_addr} !== {2'b11, exp_addr}) begin
            errors++; $display("FAIL contend2_loser_grant: got %b/%h want 11/%h",
                               {o_busy, o_mem_ren}, o_mem_addr, exp_addr);
        end
        i_mem_vd = 1'b1; i_mem_rdata = 32'h0000_C0C0;
        tick;
        i_mem_vd = 1'b0;
`ifdef MEM_ARB_RR_EN
        exp_idata = 32'h0000_B0B0; exp_ddata = 32'h0000_C0C0;
`else
        exp_ddata = 32'h0000_B0B0; exp_idata = 32'h0000_C0C0;
`endif
        checks++;
        if ({o_idata, o_ddata} !== {exp_idata, exp_ddata}) begin
            errors++; $display("FAIL contend2_data: got %h/%h want %h/%h", o_idata, o_ddata, exp_idata, exp_ddata);
        end
        tick;
    endtask

    task automatic test_write;
        // Read and write together must be treated as a write.
        i_dren = 1'b1; i_dwen = 1'b1; i_daddr = 32'h2000; i_dwdata = 32'h1234_5678;
        tick;
        i_dren = 1'b0; i_dwen = 1'b0; i_daddr = 32'hFFFF_0000; i_dwdata = 32'hBAD0_BAD0;
        i_mem_rdata = 32'h5555_5555;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({o_mem_ren, o_mem_wen, o_mem_addr, o_mem_wdata} !== {2'b01, 32'h2000, 32'h1234_5678}) begin
                errors++; $display("FAIL write_hold_%0d: got %b/%h/%h want 01/00002000/12345678",
                                   i, {o_mem_ren, o_mem_wen}, o_mem_addr, o_mem_wdata);
            end
            if (i == 4) i_mem_vd = 1'b1;
            tick;
        end
        i_mem_vd = 1'b0;
        checks++;
        if ({o_dvd, o_mem_wen, o_ddata} !== {2'b10, exp_ddata}) begin
            errors++; $display("FAIL write_complete: got %b/%h want 10/%h", {o_dvd, o_mem_wen}, o_ddata, exp_ddata);
        end
        tick;
        checks++;
        if (o_dvd !== 1'b0) begin
            errors++; $display("FAIL write_pulse_end: got %b want 0", o_dvd);
        end
    endtask

    task automatic test_drop_req;
        i_dren = 1'b1; i_daddr = 32'h300;
        tick;
        i_dren = 1'b0;
        tick;
        checks++;
        if ({o_busy, o_mem_ren, o_mem_addr} !== {2'b11, 32'h300}) begin
            errors++; $display("FAIL drop_still_busy: got %b/%h want 11/00000300", {o_busy, o_mem_ren}, o_mem_addr);
        end
        i_mem_vd = 1'b1; i_mem_rdata = 32'h0BAD_F00D;
        tick;
        i_mem_vd = 1'b0;
        exp_ddata = 32'h0BAD_F00D;
        checks++;
        if ({o_dvd, o_ddata} !== {1'b1, exp_ddata}) begin
            errors++; $display("FAIL drop_complete: got %b/%h want 1/%h", o_dvd, o_ddata, exp_ddata);
        end
        for (int i = 0; i < 2; i++) begin
            tick;
            checks++;
            if ({o_dvd, o_busy} !== 2'b00) begin
                errors++; $display("FAIL drop_single_pulse_%0d: got %b want 00", i, {o_dvd, o_busy});
            end
        end
    endtask

    task automatic test_timeout_boundary;
        i_ireq = 1'b1; i_iaddr = 32'h500;
        tick;
        i_ireq = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({t_busy, t_timeout} !== 2'b10) begin
                errors++; $display("FAIL boundary_busy_%0d: got %b want 10", i, {t_busy, t_timeout});
            end
            if (i == 3) begin
                i_mem_vd = 1'b1; i_mem_rdata = 32'h0000_0077;
            end
            tick;
        end
        i_mem_vd = 1'b0;
        checks++;
        if ({t_ivd, t_timeout, t_idata} !== {2'b10, 32'h0000_0077}) begin
            errors++; $display("FAIL boundary_vd_wins: got %b/%h want 10/00000077", {t_ivd, t_timeout}, t_idata);
        end
        exp_idata = 32'h0000_0077;
        tick;
    endtask

    task automatic test_timeout;
        i_dren = 1'b1; i_daddr = 32'h600;
        tick;
        i_dren = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({t_busy, t_timeout} !== 2'b10) begin
                errors++; $display("FAIL timeout_busy_%0d: got %b want 10", i, {t_busy, t_timeout});
            end
            tick;
        end
        checks++;
        if ({t_timeout, t_busy, t_mem_ren, t_dvd, t_ivd} !== 5'b10000) begin
            errors++; $display("FAIL timeout_pulse: got %b want 10000", {t_timeout, t_busy, t_mem_ren, t_dvd, t_ivd});
        end
        checks++;
        if (o_busy !== 1'b1) begin
            errors++; $display("FAIL timeout_long_limit_busy: got %b want 1", o_busy);
        end
        tick;
        checks++;
        if ({t_timeout, t_busy, t_dvd} !== 3'b000) begin
            errors++; $display("FAIL timeout_after: got %b want 000", {t_timeout, t_busy, t_dvd});
        end
    endtask

    // The main instance is still in DBUSY from the timeout case.
    task automatic test_reset_mid;
        rst = 1'b1;
        tick;
        checks++;
        if (main_outs !== '0) begin
            errors++; $display("FAIL rst_mid_outputs: got %h want 0", main_outs);
        end
        i_mem_vd = 1'b1; i_mem_rdata = 32'h0000_0099;
        tick;
        checks++;
        if (main_outs !== '0) begin
            errors++; $display("FAIL rst_mid_vd_ignored: got %h want 0", main_outs);
        end
        rst = 1'b0;
        tick;
        i_mem_vd = 1'b0;
        checks++;
        if ({o_dvd, o_ivd, o_busy, o_timeout, o_ddata, o_idata} !== {4'b0000, 32'h0, 32'h0}) begin
            errors++; $display("FAIL rst_late_vd: got %b/%h/%h want 0000/0/0",
                               {o_dvd, o_ivd, o_busy, o_timeout}, o_ddata, o_idata);
        end
        tick;
    endtask

    initial begin
        exp_idata = '0;
        exp_ddata = '0;
        test_reset;
        test_ifetch;
        test_contention;
        test_write;
        test_drop_req;
        test_timeout_boundary;
        test_timeout;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have parameter AW, default 32, meaning address width.
REQ-002 The module SHALL have parameter DW, default 32, meaning data width.
REQ-003 The module SHALL have parameter TIMEOUT, default 255, meaning the maximum number of busy cycles before abort.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The module SHALL have port i_ireq, input, 1 bit: instruction refill read request.
REQ-007 The module SHALL have port i_iaddr, input, AW bits: instruction address.
REQ-008 The module SHALL have port o_idata, output, DW bits: instruction read data.
REQ-009 The module SHALL have port o_ivd, output, 1 bit: instruction completion pulse.
REQ-010 The module SHALL have port i_dren, input, 1 bit: data read request.
REQ-011 The module SHALL have port i_dwen, input, 1 bit: data write request.
REQ-012 The module SHALL have port i_daddr, input, AW bits: data address.
REQ-013 The module SHALL have port i_dwdata, input, DW bits: data write value.
REQ-014 The module SHALL have port o_ddata, output, DW bits: data read result.
REQ-015 The module SHALL have port o_dvd, output, 1 bit: data completion pulse.
REQ-016 The module SHALL have memory-side ports o_mem_addr (output, AW), o_mem_ren (output, 1), o_mem_wen (output, 1), o_mem_wdata (output, DW), i_mem_rdata (input, DW) and i_mem_vd (input, 1, completes a read or a write).
REQ-017 The module SHALL have port o_busy, output, 1 bit: a transaction is in flight.
REQ-018 The module SHALL have port o_timeout, output, 1 bit: abort pulse.

Function
REQ-019 The FSM SHALL have states IDLE, IBUSY, DBUSY and DONE.
REQ-020 In IDLE, the FSM SHALL sample requests; if any request is pending it SHALL latch the winner's address, write data and type, and enter IBUSY or DBUSY on the next edge.
REQ-021 Memory outputs SHALL be registered: for a request sampled in cycle N, o_mem_* SHALL be asserted from cycle N+1 and held stable until completion.
REQ-022 When i_dren and i_dwen are high together, the arbiter SHALL treat the request as a write.
REQ-023 In a BUSY state, i_mem_vd=1 SHALL cause the following on the next edge: o_mem_ren/o_mem_wen drop, o_idata or o_ddata load i_mem_rdata (reads only), the matching o_ivd or o_dvd goes high for exactly one cycle, and the FSM enters DONE.
REQ-024 DONE SHALL last one cycle, SHALL ignore all requests, and SHALL then go to IDLE.
REQ-025 Minimum latency SHALL be: request sampled at N, i_mem_vd at N+1, vd pulse at N+2, next grant sampled at N+3.
REQ-026 A requester deasserting its request mid-transaction SHALL NOT abort it; the transaction SHALL complete and the vd pulse SHALL still be issued.
REQ-027 i_mem_vd in IDLE or DONE SHALL be ignored.
REQ-028 A busy counter SHALL clear on entry to a BUSY state and increment each BUSY cycle without i_mem_vd.
REQ-029 When the busy counter reaches TIMEOUT, the arbiter SHALL pulse o_timeout for one cycle, drop the memory strobes, issue no vd, and enter IDLE.
REQ-030 If i_mem_vd arrives in the same cycle the counter reaches TIMEOUT, completion SHALL win.
REQ-031 o_busy SHALL be 1 exactly in IBUSY and DBUSY.
REQ-032 o_idata and o_ddata SHALL hold their last value until the next completed read on that port.

Reset
REQ-033 While rst=1 the FSM SHALL enter IDLE, the counter SHALL clear, and all outputs SHALL be 0, including data outputs.
REQ-034 The last-grant register SHALL reset to instruction.
REQ-035 rst asserted mid-transaction SHALL abandon the transaction with no vd and no timeout pulse, and a late i_mem_vd SHALL be ignored.

Configuration
REQ-036 When macro MEM_ARB_RR_EN is defined and both ports request in IDLE, the arbiter SHALL grant the port not granted last and SHALL update the last-grant register on every grant.
REQ-037 When MEM_ARB_RR_EN is undefined, the data port SHALL always win and the last-grant register SHALL be absent.

Structure
REQ-038 Package mem_arb_pkg SHALL hold the FSM state enum, the port-ID constants (PORT_I, PORT_D) and the default widths.
REQ-039 The timeout counter SHALL be the sub-module mem_arb_timer, with inputs clear and enable and output expired, parameterized by TIMEOUT.

Verification
REQ-040 Scenario: i_ireq with i_iaddr=0x100, memory returns 0xDEADBEEF with i_mem_vd one cycle after o_mem_ren -> o_idata=0xDEADBEEF and o_ivd pulses at N+2.
REQ-041 Scenario: i_ireq and i_dren at the same cycle, without the macro -> data granted first and instruction granted after DONE; with MEM_ARB_RR_EN, two consecutive contention rounds -> grants are D then I.
REQ-042 Scenario: i_dwen with i_daddr=0x2000 and i_dwdata=0x12345678 -> o_mem_wen with both values held stable for 5 cycles until i_mem_vd -> o_dvd pulses and o_ddata is unchanged.
REQ-043 Scenario: TIMEOUT=4 and i_mem_vd never asserted -> o_timeout pulses after 4 busy cycles, with no vd and the FSM in IDLE.
REQ-044 Scenario: rst asserted during DBUSY, then i_mem_vd -> no o_dvd, and all outputs are 0 during rst.
REQ-045 Scenario: i_dren dropped one cycle after grant -> the read still completes and o_dvd pulses once.
